// File: rtl/alien_formation_mover.sv
`default_nettype none
// ============================================================================
// Module      : alien_formation_mover
// Description : Per-frame motion controller for the alien formation. Sweeps
//               right / down / left / down in sub-pixel fixed point. The edges
//               follow the surviving columns, the speed grows with kills, the
//               block can freeze or restart, and it flags a landed formation.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_formation_mover #(
  parameter int INIT_X      = 40,
  parameter int INIT_Y      = 40,
  parameter int LEFT_BOUND  = 40,
  parameter int RIGHT_BOUND = 599,
  parameter int BOTTOM_Y    = 400,
  parameter int Y_GAP       = 8,
  parameter int FRAC_BITS   = 6,
  parameter int BASE_SPEED  = 32,
  parameter int SPEED_STEP  = 4,
  parameter int MAX_ALIENS  = 40,
  parameter int TURBO_MULT  = 10,
  parameter int ALIVE_W     = 6
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                turbo,
  input  logic                freeze,
  input  logic                restart,
  input  logic [ALIVE_W-1:0]  aliveCount,
  input  logic [10:0]         leftColOffset,
  input  logic [10:0]         rightColOffset,
  output logic signed [10:0]  topLeftX,
  output logic signed [10:0]  topLeftY,
  output logic                movingRight,
  output logic                stepDown,
  output logic                landed
);

  localparam logic [2:0] S_RIGHT  = 3'd0;
  localparam logic [2:0] S_DOWN_L = 3'd1;
  localparam logic [2:0] S_LEFT   = 3'd2;
  localparam logic [2:0] S_DOWN_R = 3'd3;
  localparam logic [2:0] S_LANDED = 3'd4;

  // One pixel in fixed-point units, and the fixed-point forms of the constants.
  localparam int ONE_PX    = 1 << FRAC_BITS;
  localparam int X_INIT_FP = INIT_X * ONE_PX;
  localparam int Y_INIT_FP = INIT_Y * ONE_PX;
  localparam int Y_GAP_FP  = Y_GAP * ONE_PX;
  localparam int BOTTOM_FP = BOTTOM_Y * ONE_PX;

  logic [2:0]         state_q, state_d;
  logic signed [31:0] xFp_q, xFp_d;
  logic signed [31:0] yFp_q, yFp_d;
  logic signed [31:0] yTarget_q, yTarget_d;
  logic signed [31:0] speed_q, speed_d;
  logic               stepDown_q, stepDown_d;
  logic               landed_q, landed_d;

  logic signed [31:0] aliveExt;
  logic signed [31:0] aliveSat;
  logic signed [31:0] speedBase;
  logic signed [31:0] speedNew;
  logic signed [31:0] xMax;
  logic signed [31:0] xMin;
  logic signed [31:0] xStep;
  logic signed [31:0] yStep;

  // Kill-scaled speed and live-column edge limits, all in fixed point.
  always_comb begin
    aliveExt  = {{(32-ALIVE_W){1'b0}}, aliveCount};
    aliveSat  = (aliveExt > MAX_ALIENS) ? MAX_ALIENS : aliveExt;
    speedBase = BASE_SPEED + (MAX_ALIENS - aliveSat) * SPEED_STEP;
    speedNew  = turbo ? speedBase * TURBO_MULT : speedBase;
    xMax      = (RIGHT_BOUND - $signed({21'd0, rightColOffset})) * ONE_PX;
    xMin      = (LEFT_BOUND  - $signed({21'd0, leftColOffset}))  * ONE_PX;
  end

  // State and position registers; reset lands directly on the start position.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_RIGHT;
      xFp_q      <= X_INIT_FP;
      yFp_q      <= Y_INIT_FP;
      yTarget_q  <= Y_INIT_FP;
      speed_q    <= BASE_SPEED;
      stepDown_q <= 1'b0;
      landed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      xFp_q      <= xFp_d;
      yFp_q      <= yFp_d;
      yTarget_q  <= yTarget_d;
      speed_q    <= speed_d;
      stepDown_q <= stepDown_d;
      landed_q   <= landed_d;
    end
  end

  // Next-state: restart wins, otherwise move only on an unfrozen frame pulse.
  always_comb begin
    state_d    = state_q;
    xFp_d      = xFp_q;
    yFp_d      = yFp_q;
    yTarget_d  = yTarget_q;
    speed_d    = speedNew;
    stepDown_d = 1'b0;
    xStep      = xFp_q;
    yStep      = yFp_q;
    if (restart) begin
      state_d   = S_RIGHT;
      xFp_d     = X_INIT_FP;
      yFp_d     = Y_INIT_FP;
      yTarget_d = Y_INIT_FP;
      speed_d   = BASE_SPEED;
    end else if (startOfFrame && !freeze) begin
      case (state_q)
        S_RIGHT: begin
          xStep = xFp_q + speed_q;
          if (xStep >= xMax) begin
            // Clamping also catches a formation already past a moved edge.
            xFp_d      = xMax;
            yTarget_d  = yFp_q + Y_GAP_FP;
            stepDown_d = 1'b1;
            state_d    = S_DOWN_L;
          end else begin
            xFp_d = xStep;
          end
        end
        S_LEFT: begin
          xStep = xFp_q - speed_q;
          if (xStep <= xMin) begin
            xFp_d      = xMin;
            yTarget_d  = yFp_q + Y_GAP_FP;
            stepDown_d = 1'b1;
            state_d    = S_DOWN_R;
          end else begin
            xFp_d = xStep;
          end
        end
        S_DOWN_L, S_DOWN_R: begin
          yStep = yFp_q + speed_q;
          if (yStep > yTarget_q) begin
            yStep = yTarget_q;
          end
          yFp_d = yStep;
          // Reaching the bottom beats finishing the descent.
          if (yStep >= BOTTOM_FP) begin
            state_d = S_LANDED;
          end else if (yStep == yTarget_q) begin
            state_d = (state_q == S_DOWN_L) ? S_LEFT : S_RIGHT;
          end
        end
        default: begin
          // Landed (and any unused code) holds position until restart.
        end
      endcase
    end
    landed_d = (state_d == S_LANDED);
  end

  // Outputs: pixel positions are the floor of the fixed-point registers.
  always_comb begin
    topLeftX    = xFp_q[FRAC_BITS+10:FRAC_BITS];
    topLeftY    = yFp_q[FRAC_BITS+10:FRAC_BITS];
    movingRight = (state_q == S_RIGHT) || (state_q == S_DOWN_R);
    stepDown    = stepDown_q;
    landed      = landed_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alien_formation_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_alien_formation_mover
// Description : Bench for alien_formation_mover. A frame-level reference model
//               predicts the outputs every clock into a scoreboard queue that
//               a monitor drains; directed checks cover the sweep landmarks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_formation_mover;

  localparam int ONE = 64;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               turbo = 1'b0;
  logic               freeze = 1'b0;
  logic               restart = 1'b0;
  logic [5:0]         aliveCount = 6'd40;
  logic [10:0]        leftColOffset = 11'd0;
  logic [10:0]        rightColOffset = 11'd448;
  logic signed [10:0] topLeftX, topLeftY;
  logic               movingRight, stepDown, landed;

  alien_formation_mover dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .turbo(turbo),
    .freeze(freeze), .restart(restart), .aliveCount(aliveCount),
    .leftColOffset(leftColOffset), .rightColOffset(rightColOffset),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .movingRight(movingRight),
    .stepDown(stepDown), .landed(landed)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit mr; bit sd; bit ld; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: positions in 1/64 px, phase 0=right 1=down-then-left
  // 2=left 3=down-then-right 4=landed.
  int m_x, m_y, m_tgt, m_spd, m_ph;
  bit m_sd;

  function automatic int floor_px(int v);
    if (v >= 0) return v / ONE;
    return -((-v + ONE - 1) / ONE);
  endfunction

  function automatic int speed_for(int alive, bit t);
    int a = (alive > 40) ? 40 : alive;
    int s = 32 + (40 - a) * 4;
    return t ? s * 10 : s;
  endfunction

  task automatic model_init();
    m_x = 40 * ONE; m_y = 40 * ONE; m_tgt = m_y; m_spd = 32; m_ph = 0; m_sd = 0;
  endtask

  task automatic model_clock();
    int right_lim = (599 - int'(rightColOffset)) * ONE;
    int left_lim  = (40 - int'(leftColOffset)) * ONE;
    int nxt;
    m_sd = 0;
    if (restart) begin
      model_init();
    end else begin
      if (startOfFrame && !freeze) begin
        if (m_ph == 0) begin
          nxt = m_x + m_spd;
          if (nxt >= right_lim) begin
            m_x = right_lim; m_tgt = m_y + 8 * ONE; m_sd = 1; m_ph = 1;
          end else m_x = nxt;
        end else if (m_ph == 2) begin
          nxt = m_x - m_spd;
          if (nxt <= left_lim) begin
            m_x = left_lim; m_tgt = m_y + 8 * ONE; m_sd = 1; m_ph = 3;
          end else m_x = nxt;
        end else if (m_ph == 1 || m_ph == 3) begin
          m_y = (m_y + m_spd < m_tgt) ? m_y + m_spd : m_tgt;
          if (m_y >= 400 * ONE) m_ph = 4;
          else if (m_y == m_tgt) m_ph = (m_ph == 1) ? 2 : 0;
        end
      end
      m_spd = speed_for(int'(aliveCount), turbo);
    end
  endtask

  // Model runs alongside the DUT and queues the expected post-edge outputs.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      model_init();
      sb.delete();
    end else begin
      exp_t e;
      model_clock();
      e.x = floor_px(m_x); e.y = floor_px(m_y);
      e.mr = (m_ph == 0 || m_ph == 3); e.sd = m_sd; e.ld = (m_ph == 4);
      sb.push_back(e);
    end
  end

  // Monitor: pops one expectation per clock and compares on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (int'(topLeftX) != e.x || int'(topLeftY) != e.y || movingRight != e.mr ||
          stepDown != e.sd || landed != e.ld) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got x=%0d y=%0d mr=%0b sd=%0b ld=%0b, required x=%0d y=%0d mr=%0b sd=%0b ld=%0b",
                 $time, topLeftX, topLeftY, movingRight, stepDown, landed,
                 e.x, e.y, e.mr, e.sd, e.ld);
      end
    end
  end

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic frame();
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset between clock edges so it can only act asynchronously.
  task automatic do_reset();
    @(negedge clk); #2 resetN = 1'b0; #1;
  endtask

  task automatic release_reset();
    @(negedge clk); resetN = 1'b1;
  endtask

  task automatic chk_home(string tag);
    chk({tag, "_x"}, int'(topLeftX), 40);
    chk({tag, "_y"}, int'(topLeftY), 40);
    chk({tag, "_mr"}, int'(movingRight), 1);
    chk({tag, "_sd"}, int'(stepDown), 0);
    chk({tag, "_ld"}, int'(landed), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle(3);
    chk_home("reset");
    release_reset();

    // Default sweep: 222 frames to the right edge, 16 to descend 8 px.
    repeat (221) frame();
    chk("sweep_x221", int'(topLeftX), 150);
    frame();
    chk("sweep_x222", int'(topLeftX), 151);
    chk("sweep_sd", int'(stepDown), 1);
    chk("sweep_mr", int'(movingRight), 0);
    repeat (15) frame();
    chk("desc_y15", int'(topLeftY), 47);
    frame();
    chk("desc_y16", int'(topLeftY), 48);
    frame();
    chk("left_x", int'(topLeftX), 150);
    chk("left_mr", int'(movingRight), 0);

    // Frozen frames are dropped, not caught up.
    freeze = 1'b1;
    repeat (10) frame();
    chk("freeze_x", int'(topLeftX), 150);
    freeze = 1'b0;
    repeat (2) frame();
    chk("unfreeze_x", int'(topLeftX), 149);

    // Turbo: 5 px per frame, clamp at 151.
    do_reset();
    chk_home("areset1");
    release_reset();
    turbo = 1'b1;
    frame();
    chk("turbo_x1", int'(topLeftX), 45);
    repeat (21) frame();
    chk("turbo_x22", int'(topLeftX), 150);
    frame();
    chk("turbo_clamp", int'(topLeftX), 151);
    chk("turbo_sd", int'(stepDown), 1);

    // Reset in the middle of a descent acts without a clock.
    do_reset();
    chk_home("areset_desc");
    turbo = 1'b0;
    release_reset();

    // Kill-scaled speed and its saturation.
    aliveCount = 6'd30;
    repeat (8) frame();
    chk("alive30_x", int'(topLeftX), 49);
    do_reset();
    aliveCount = 6'd50;
    release_reset();
    repeat (8) frame();
    chk("alive50_x", int'(topLeftX), 44);

    // Left edge beyond the bound: turn at -24.
    do_reset();
    aliveCount = 6'd0;
    turbo = 1'b1;
    leftColOffset = 11'd64;
    release_reset();
    repeat (5) frame();
    chk("fast_left_mr", int'(movingRight), 0);
    k = 0;
    while (!movingRight && k < 50) begin frame(); k++; end
    chk("neg_turn_mr", int'(movingRight), 1);
    chk("neg_turn_x", int'(topLeftX), -24);

    // Run to the bottom, stay put, then restart.
    k = 0;
    while (!landed && k < 600) begin frame(); k++; end
    chk("landed", int'(landed), 1);
    chk("landed_y", int'(topLeftY), 400);
    repeat (5) frame();
    chk("landed_hold_y", int'(topLeftY), 400);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    chk_home("restart");

    // Randomised traffic against the model.
    leftColOffset = 11'd0;
    turbo = 1'b0;
    aliveCount = 6'd40;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) aliveCount = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) turbo = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        leftColOffset  = 11'($urandom_range(0, 448));
        rightColOffset = 11'($urandom_range(0, 448));
      end
      freeze = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        restart = 1'b1;
        @(negedge clk); restart = 1'b0;
      end
      frame();
      idle($urandom_range(0, 2));
    end
    freeze = 1'b0;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alien_formation_mover.md
# alien_formation_mover

Parametrised motion controller for the alien formation in the game pipeline. It produces the formation's top-left pixel position each frame using a right / down / left / down sweep with sub-pixel fixed-point stepping. Compared with the earlier single-speed mover it adds four behaviours: boundary edges that track the surviving columns, speed that scales with kills, freeze/restart controls, and a landed indication. Its outputs feed the formation bitmap/draw block and the game-state controller.

## Interface
- INIT_X, 40: initial formation top-left X in pixels.
- INIT_Y, 40: initial formation top-left Y in pixels.
- LEFT_BOUND, 40: leftmost allowed pixel for the left edge of the live formation.
- RIGHT_BOUND, 599: rightmost allowed pixel for the right edge of the live formation.
- BOTTOM_Y, 400: top-left Y at or beyond which the formation has landed.
- Y_GAP, 8: pixels descended per down phase.
- FRAC_BITS, 6: fixed-point fraction bits; one pixel is 2^FRAC_BITS units.
- BASE_SPEED, 32: speed in fixed-point units per frame with all aliens alive.
- SPEED_STEP, 4: fixed-point units per frame added per dead alien.
- MAX_ALIENS, 40: formation population.
- TURBO_MULT, 10: speed multiplier applied while turbo is high.
- ALIVE_W, 6: width of aliveCount.
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-clk pulse per frame; the only motion enable.
- turbo, in, 1: speed multiplier select.
- freeze, in, 1: while high, position and state hold.
- restart, in, 1: synchronous return to the initial condition.
- aliveCount, in, ALIVE_W: aliens alive. Values above MAX_ALIENS are treated as MAX_ALIENS.
- leftColOffset, in, 11: pixel offset from top-left to the left edge of the leftmost live column.
- rightColOffset, in, 11: pixel offset from top-left to the right edge of the rightmost live column.
- topLeftX, out, signed 11: formation X in pixels.
- topLeftY, out, signed 11: formation Y in pixels.
- movingRight, out, 1: 1 in S_RIGHT and S_DOWN_R, 0 in S_LEFT and S_DOWN_L.
- stepDown, out, 1: one-clk pulse on entry to either down state.
- landed, out, 1: high in S_LANDED.

## Operation
- Internal registers: signed 32-bit xFp and yFp, yTarget, speed, and state.
- Outputs are arithmetic shifts: topLeftX = xFp >>> FRAC_BITS and topLeftY = yFp >>> FRAC_BITS (floor toward -inf).
- speed is registered every clk as (BASE_SPEED + (MAX_ALIENS - min(aliveCount, MAX_ALIENS)) * SPEED_STEP) * (turbo ? TURBO_MULT : 1).
- Edge limits in fixed point: xMax = (RIGHT_BOUND - rightColOffset) << F and xMin = (LEFT_BOUND - leftColOffset) << F. xMin may be negative.
- States: S_RIGHT, S_DOWN_L, S_LEFT, S_DOWN_R, S_LANDED. Updates happen only on a startOfFrame cycle with freeze=0.
- S_RIGHT: xN = xFp + speed.
  - If xN >= xMax: xFp <= xMax (clamped), yTarget <= yFp + (Y_GAP << F), stepDown=1, go to S_DOWN_L.
  - Otherwise xFp <= xN.
- S_LEFT mirrors S_RIGHT: xN = xFp - speed. If xN <= xMin, clamp xFp to xMin, set yTarget, pulse stepDown, go to S_DOWN_R.
- S_DOWN_L / S_DOWN_R: yFp <= min(yFp + speed, yTarget).
  - If the new yFp >= BOTTOM_Y << F, go to S_LANDED. This check takes precedence.
  - Otherwise, if the new yFp == yTarget, go to S_LEFT / S_RIGHT respectively.
- S_LANDED is terminal: position holds and landed=1 until restart or reset.
- X never moves in the down states; Y never moves in the horizontal states.
- If offsets change so that xFp is already past a limit, the next frame update clamps xFp to the limit and turns the formation.

## Timing
- On reset (asynchronous): xFp = INIT_X << F, yFp = INIT_Y << F, state S_RIGHT, speed = BASE_SPEED, stepDown = 0, landed = 0. So topLeftX = INIT_X, topLeftY = INIT_Y, movingRight = 1.
- restart is synchronous, has the highest priority over freeze and startOfFrame, and produces the reset values on the next clk.
- Latency: position and state update on the clk edge of the startOfFrame cycle. Outputs are visible the following cycle.
- stepDown and landed are registered: stepDown rises in the same cycle the state enters a down state.
- speed uses the value registered in the previous clk. A change on turbo or aliveCount takes effect on the second clk after the change.
- freeze=1 while startOfFrame is high means that frame is skipped, with no catch-up.
- Reset asserted mid-sweep forces the reset values immediately, with no clk required.

## Test plan
- Defaults, aliveCount=40, offsets 0/448, 222 startOfFrame pulses: topLeftX steps from 40 to 151 and stepDown pulses on the 222nd frame with the state in S_DOWN_L. Sixteen more frames take topLeftY from 40 to 48, then the formation moves left.
- turbo=1 from reset: topLeftX advances 5 px per frame. The frame that would pass 151 clamps topLeftX to exactly 151.
- aliveCount=30: speed becomes 72 units (1.125 px per frame). With aliveCount=50 the speed is 32, i.e. the value is clamped.
- leftColOffset=64 while in S_LEFT: the formation turns at topLeftX = -24, and the signed output is correct.
- Set BOTTOM_Y=48 and run to the first descent: topLeftY reaches 48, landed=1, and further frames produce no motion. restart=1 for one clk returns topLeftX to 40, topLeftY to 40, landed to 0.
- freeze held for 10 frames mid-sweep: outputs are constant. Asserting resetN=0 mid-descent gives the reset values asynchronously.
